// File: rtl/mem_arb_pkg.sv
// Shared types and reset constants for the unified memory-port arbiter.
// The arbiter FSM, the owner encoding and the round-robin picker all use them.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam arb_state_t RST_STATE      = IDLE;
    localparam owner_t     RST_LAST_OWNER = OWN_I;
    localparam owner_t     RST_OWNER      = OWN_I;

    // The side that did not win the previous grant gets priority on a tie.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the fetch side and the
// load/store side. A tie goes to whichever side was not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   i_req_d,
    input  owner_t i_last_owner,
    output logic   o_valid,
    output owner_t o_owner
);

    always_comb begin
        o_valid = i_req_i | i_req_d;
        o_owner = OWN_I;
        if (i_req_i && i_req_d) begin
            o_owner = other_owner(i_last_owner);
        end else if (i_req_d) begin
            o_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store
// requesters, one transaction in flight, round-robin on simultaneous requests.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                n_rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                busy,
    output logic                proto_err,
    output arb_state_t          dbg_state
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    owner_t              r_owner;
    owner_t              r_last_owner;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [BE_W-1:0]     r_m_be;
    logic                r_proto_err;

    logic                w_pick_valid;
    owner_t              w_pick_owner;
    logic                w_capture;
    logic                w_gnt_fire;
    logic                w_rsp_fire;
    logic                w_proto_hit;

    logic                w_cap_we;
    logic [ADDR_W-1:0]   w_cap_addr;
    logic [DATA_W-1:0]   w_cap_wdata;
    logic [BE_W-1:0]     w_cap_be;

    rr_arb2 u_rr_arb2 (
        .i_req_i      (i_req),
        .i_req_d      (d_req),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );

    // Fetches never write, so their store fields are forced to a clean read.
    always_comb begin
        if (w_pick_owner == OWN_D) begin
            w_cap_we    = d_we;
            w_cap_addr  = d_addr;
            w_cap_wdata = d_wdata;
            w_cap_be    = d_be;
        end else begin
            w_cap_we    = 1'b0;
            w_cap_addr  = i_addr;
            w_cap_wdata = '0;
            w_cap_be    = '1;
        end
    end

    // An m_rvalid coincident with m_gnt is dropped here; only the grant counts.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_gnt_fire  = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (m_gnt) begin
                    w_gnt_fire  = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_proto_hit = (m_rvalid && (r_state != RESP)) ||
                         (m_gnt    && (r_state != REQ));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= RST_STATE;
            r_owner      <= RST_OWNER;
            r_last_owner <= RST_LAST_OWNER;
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_owner <= w_pick_owner;
            end
            if (w_gnt_fire) begin
                r_last_owner <= r_owner;
            end
            if (w_proto_hit) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Request fields are loaded once per transaction and held until the next.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_be    <= '0;
        end else if (w_capture) begin
            r_m_we    <= w_cap_we;
            r_m_addr  <= w_cap_addr;
            r_m_wdata <= w_cap_wdata;
            r_m_be    <= w_cap_be;
        end
    end

    assign m_req     = (r_state == REQ);
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_be      = r_m_be;

    assign i_gnt     = w_gnt_fire && (r_owner == OWN_I);
    assign d_gnt     = w_gnt_fire && (r_owner == OWN_D);
    assign i_rvalid  = w_rsp_fire && (r_owner == OWN_I);
    assign d_rvalid  = w_rsp_fire && (r_owner == OWN_D);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    assign busy      = (r_state != IDLE);
    assign proto_err = r_proto_err;
    assign dbg_state = r_state;

endmodule
